axi_lite_to_axi_pc: RTL and testbench

Protocol converter from AXI4 Lite (slave side) to AXI4 (master side), used where an AXI Lite master must reach an AXI4-only interconnect or slave. Each AXI Lite access becomes one single-beat AXI4 burst with a fixed ID. At most one write and one read are in flight at a time; read and write paths are independent and may run concurrently. AW and W are buffered independently on the Lite side, so they may arrive in any order or in the same cycle.

---
 rtl/axi_lite_to_axi_pc.sv | 225 ++++++++++++++++++++++
 tb/tb_axi_lite_to_axi_pc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_to_axi_pc.sv
// AXI4-Lite slave to AXI4 master protocol converter: each Lite access becomes one single-beat INCR burst with a fixed ID.
// Latency: Lite AW+W (or AR) accepted in cycle n is presented on the AXI4 side in cycle n+1; B and R return combinationally.
// Backpressure: one write and one read in flight; Lite readies stay low until the previous response has handshaked.
//
// Ports: Clk_CI / Rst_RBI (async, active low); lite_* = AXI-Lite slave (aw, w, b, ar, r);
//        axi_* = AXI4 master (aw, w, b, ar, r). b_user / r_user are not carried.
// Optional: define AXI_LITE_TO_AXI_RESP_CHECK_EN to turn unexpected b_id / r_id / r_last into SLVERR.
module axi_lite_to_axi_pc #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_USER_WIDTH = 1,
  parameter int AXI_ID_VALUE   = 0
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RBI,
  // AXI-Lite slave side
  input  logic [AXI_ADDR_WIDTH-1:0]   lite_aw_addr,
  input  logic                        lite_aw_valid,
  output logic                        lite_aw_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   lite_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] lite_w_strb,
  input  logic                        lite_w_valid,
  output logic                        lite_w_ready,
  output logic [1:0]                  lite_b_resp,
  output logic                        lite_b_valid,
  input  logic                        lite_b_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   lite_ar_addr,
  input  logic                        lite_ar_valid,
  output logic                        lite_ar_ready,
  output logic [AXI_DATA_WIDTH-1:0]   lite_r_data,
  output logic [1:0]                  lite_r_resp,
  output logic                        lite_r_valid,
  input  logic                        lite_r_ready,
  // AXI4 master side
  output logic [AXI_ID_WIDTH-1:0]     axi_aw_id,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
  output logic [7:0]                  axi_aw_len,
  output logic [2:0]                  axi_aw_size,
  output logic [1:0]                  axi_aw_burst,
  output logic                        axi_aw_lock,
  output logic [3:0]                  axi_aw_cache,
  output logic [2:0]                  axi_aw_prot,
  output logic [3:0]                  axi_aw_qos,
  output logic [3:0]                  axi_aw_region,
  output logic [5:0]                  axi_aw_atop,
  output logic [AXI_USER_WIDTH-1:0]   axi_aw_user,
  output logic                        axi_aw_valid,
  input  logic                        axi_aw_ready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
  output logic                        axi_w_last,
  output logic [AXI_USER_WIDTH-1:0]   axi_w_user,
  output logic                        axi_w_valid,
  input  logic                        axi_w_ready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_b_id,
  input  logic [1:0]                  axi_b_resp,
  input  logic                        axi_b_valid,
  output logic                        axi_b_ready,
  output logic [AXI_ID_WIDTH-1:0]     axi_ar_id,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr,
  output logic [7:0]                  axi_ar_len,
  output logic [2:0]                  axi_ar_size,
  output logic [1:0]                  axi_ar_burst,
  output logic                        axi_ar_lock,
  output logic [3:0]                  axi_ar_cache,
  output logic [2:0]                  axi_ar_prot,
  output logic [3:0]                  axi_ar_qos,
  output logic [3:0]                  axi_ar_region,
  output logic [AXI_USER_WIDTH-1:0]   axi_ar_user,
  output logic                        axi_ar_valid,
  input  logic                        axi_ar_ready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_r_id,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data,
  input  logic [1:0]                  axi_r_resp,
  input  logic                        axi_r_last,
  input  logic                        axi_r_valid,
  output logic                        axi_r_ready
);

  localparam logic [AXI_ID_WIDTH-1:0] ID_VAL = AXI_ID_WIDTH'(AXI_ID_VALUE);
  localparam logic [2:0] SIZE_VAL = 3'($clog2(AXI_DATA_WIDTH/8));

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_RESP} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic                        aw_buf_vld, w_buf_vld, aw_done, w_done;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_q, ar_addr_q;
  logic [AXI_DATA_WIDTH-1:0]   w_data_q;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb_q;

  logic aw_acc, w_acc, aw_hs, w_hs, b_hs, ar_acc, ar_hs, r_hs;

  // Constant AXI4 burst attributes: single beat, full bus width, INCR.
  assign axi_aw_id     = ID_VAL;
  assign axi_aw_addr   = aw_addr_q;
  assign axi_aw_len    = 8'd0;
  assign axi_aw_size   = SIZE_VAL;
  assign axi_aw_burst  = 2'b01;
  assign axi_aw_lock   = 1'b0;
  assign axi_aw_cache  = 4'd0;
  assign axi_aw_prot   = 3'd0;
  assign axi_aw_qos    = 4'd0;
  assign axi_aw_region = 4'd0;
  assign axi_aw_atop   = 6'd0;
  assign axi_aw_user   = '0;
  assign axi_w_data    = w_data_q;
  assign axi_w_strb    = w_strb_q;
  assign axi_w_last    = 1'b1;
  assign axi_w_user    = '0;
  assign axi_ar_id     = ID_VAL;
  assign axi_ar_addr   = ar_addr_q;
  assign axi_ar_len    = 8'd0;
  assign axi_ar_size   = SIZE_VAL;
  assign axi_ar_burst  = 2'b01;
  assign axi_ar_lock   = 1'b0;
  assign axi_ar_cache  = 4'd0;
  assign axi_ar_prot   = 3'd0;
  assign axi_ar_qos    = 4'd0;
  assign axi_ar_region = 4'd0;
  assign axi_ar_user   = '0;

  // Handshake-facing outputs. Lite readies are additionally gated by reset so
  // nothing is accepted while the block is held in reset.
  assign lite_aw_ready = Rst_RBI && (w_state == W_IDLE) && !aw_buf_vld;
  assign lite_w_ready  = Rst_RBI && (w_state == W_IDLE) && !w_buf_vld;
  assign axi_aw_valid  = (w_state == W_ISSUE) && !aw_done;
  assign axi_w_valid   = (w_state == W_ISSUE) && !w_done;
  assign lite_b_valid  = (w_state == W_RESP) && axi_b_valid;
  assign axi_b_ready   = (w_state == W_RESP) && lite_b_ready;
  assign lite_ar_ready = Rst_RBI && (r_state == R_IDLE);
  assign axi_ar_valid  = (r_state == R_ISSUE);
  assign lite_r_valid  = (r_state == R_RESP) && axi_r_valid;
  assign axi_r_ready   = (r_state == R_RESP) && lite_r_ready;
  assign lite_r_data   = axi_r_data;

  assign aw_acc = lite_aw_valid && lite_aw_ready;
  assign w_acc  = lite_w_valid && lite_w_ready;
  assign aw_hs  = axi_aw_valid && axi_aw_ready;
  assign w_hs   = axi_w_valid && axi_w_ready;
  assign b_hs   = lite_b_valid && lite_b_ready;
  assign ar_acc = lite_ar_valid && lite_ar_ready;
  assign ar_hs  = axi_ar_valid && axi_ar_ready;
  assign r_hs   = lite_r_valid && lite_r_ready;

`ifdef AXI_LITE_TO_AXI_RESP_CHECK_EN
  // A response that does not belong to our fixed ID (or a read that is not the
  // last beat) means the downstream is misbehaving: report it as SLVERR.
  assign lite_b_resp = (axi_b_id != ID_VAL) ? 2'b10 : axi_b_resp;
  assign lite_r_resp = ((axi_r_id != ID_VAL) || !axi_r_last) ? 2'b10 : axi_r_resp;
`else
  assign lite_b_resp = axi_b_resp;
  assign lite_r_resp = axi_r_resp;
  logic unused_resp_fields;
  assign unused_resp_fields = ^{axi_b_id, axi_r_id, axi_r_last};
`endif

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      // Flags set in this same cycle count, so AW and W arriving together
      // move straight to W_ISSUE.
      W_IDLE:  if ((aw_buf_vld || aw_acc) && (w_buf_vld || w_acc)) w_state_nxt = W_ISSUE;
      W_ISSUE: if ((aw_done || aw_hs) && (w_done || w_hs)) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_acc) r_state_nxt = R_ISSUE;
      R_ISSUE: if (ar_hs) r_state_nxt = R_RESP;
      R_RESP:  if (r_hs) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      aw_buf_vld <= 1'b0;
      w_buf_vld  <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      ar_addr_q  <= '0;
    end else begin
      if (aw_acc) begin
        aw_buf_vld <= 1'b1;
        aw_addr_q  <= lite_aw_addr;
      end
      if (w_acc) begin
        w_buf_vld <= 1'b1;
        w_data_q  <= lite_w_data;
        w_strb_q  <= lite_w_strb;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs) begin
        aw_buf_vld <= 1'b0;
        w_buf_vld  <= 1'b0;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end
      if (ar_acc) ar_addr_q <= lite_ar_addr;
    end
  end

endmodule

// File: tb/tb_axi_lite_to_axi_pc.sv
// Directed bench for axi_lite_to_axi_pc: write/read conversion, back-pressure, error responses, mid-transaction reset.
module tb_axi_lite_to_axi_pc;

  logic        Clk_CI = 1'b0;
  logic        Rst_RBI;
  logic [31:0] lite_aw_addr, lite_ar_addr;
  logic        lite_aw_valid, lite_aw_ready, lite_w_valid, lite_w_ready;
  logic [63:0] lite_w_data, lite_r_data;
  logic [7:0]  lite_w_strb;
  logic [1:0]  lite_b_resp, lite_r_resp;
  logic        lite_b_valid, lite_b_ready, lite_ar_valid, lite_ar_ready;
  logic        lite_r_valid, lite_r_ready;
  logic [9:0]  axi_aw_id, axi_ar_id, axi_b_id, axi_r_id;
  logic [31:0] axi_aw_addr, axi_ar_addr;
  logic [7:0]  axi_aw_len, axi_ar_len;
  logic [2:0]  axi_aw_size, axi_ar_size, axi_aw_prot, axi_ar_prot;
  logic [1:0]  axi_aw_burst, axi_ar_burst, axi_b_resp, axi_r_resp;
  logic        axi_aw_lock, axi_ar_lock;
  logic [3:0]  axi_aw_cache, axi_ar_cache, axi_aw_qos, axi_ar_qos, axi_aw_region, axi_ar_region;
  logic [5:0]  axi_aw_atop;
  logic [0:0]  axi_aw_user, axi_ar_user, axi_w_user;
  logic        axi_aw_valid, axi_aw_ready, axi_w_valid, axi_w_ready, axi_w_last;
  logic [63:0] axi_w_data, axi_r_data;
  logic [7:0]  axi_w_strb;
  logic        axi_b_valid, axi_b_ready, axi_ar_valid, axi_ar_ready;
  logic        axi_r_last, axi_r_valid, axi_r_ready;

  int n_pass  = 0;
  int n_total = 0;

  axi_lite_to_axi_pc dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
    .lite_aw_addr(lite_aw_addr), .lite_aw_valid(lite_aw_valid), .lite_aw_ready(lite_aw_ready),
    .lite_w_data(lite_w_data), .lite_w_strb(lite_w_strb), .lite_w_valid(lite_w_valid), .lite_w_ready(lite_w_ready),
    .lite_b_resp(lite_b_resp), .lite_b_valid(lite_b_valid), .lite_b_ready(lite_b_ready),
    .lite_ar_addr(lite_ar_addr), .lite_ar_valid(lite_ar_valid), .lite_ar_ready(lite_ar_ready),
    .lite_r_data(lite_r_data), .lite_r_resp(lite_r_resp), .lite_r_valid(lite_r_valid), .lite_r_ready(lite_r_ready),
    .axi_aw_id(axi_aw_id), .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len), .axi_aw_size(axi_aw_size),
    .axi_aw_burst(axi_aw_burst), .axi_aw_lock(axi_aw_lock), .axi_aw_cache(axi_aw_cache), .axi_aw_prot(axi_aw_prot),
    .axi_aw_qos(axi_aw_qos), .axi_aw_region(axi_aw_region), .axi_aw_atop(axi_aw_atop), .axi_aw_user(axi_aw_user),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
    .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last), .axi_w_user(axi_w_user),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready),
    .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
    .axi_ar_burst(axi_ar_burst), .axi_ar_lock(axi_ar_lock), .axi_ar_cache(axi_ar_cache), .axi_ar_prot(axi_ar_prot),
    .axi_ar_qos(axi_ar_qos), .axi_ar_region(axi_ar_region), .axi_ar_user(axi_ar_user),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready)
  );

  always #5 Clk_CI = ~Clk_CI;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change just after the falling edge; outputs are checked 1 time unit later.
  task automatic nxt;
    @(negedge Clk_CI);
  endtask

  logic [1:0] exp_id_resp;

  initial begin
`ifdef AXI_LITE_TO_AXI_RESP_CHECK_EN
    exp_id_resp = 2'b10;
`else
    exp_id_resp = 2'b00;
`endif
    Rst_RBI = 1'b0;
    lite_aw_addr = '0; lite_aw_valid = 0; lite_w_data = '0; lite_w_strb = '0; lite_w_valid = 0;
    lite_b_ready = 0; lite_ar_addr = '0; lite_ar_valid = 0; lite_r_ready = 0;
    axi_aw_ready = 0; axi_w_ready = 0; axi_b_id = '0; axi_b_resp = '0; axi_b_valid = 0;
    axi_ar_ready = 0; axi_r_id = '0; axi_r_data = '0; axi_r_resp = '0; axi_r_last = 1; axi_r_valid = 0;

    // Reset state
    nxt; #1;
    check("rst_lite_aw_ready", lite_aw_ready, 0);
    check("rst_lite_w_ready", lite_w_ready, 0);
    check("rst_lite_ar_ready", lite_ar_ready, 0);
    check("rst_axi_aw_valid", axi_aw_valid, 0);
    check("rst_axi_w_valid", axi_w_valid, 0);
    check("rst_axi_ar_valid", axi_ar_valid, 0);
    check("rst_lite_b_valid", lite_b_valid, 0);
    check("rst_lite_r_valid", lite_r_valid, 0);
    nxt; Rst_RBI = 1'b1; #1;
    check("idle_aw_ready", lite_aw_ready, 1);
    check("idle_w_ready", lite_w_ready, 1);
    check("idle_ar_ready", lite_ar_ready, 1);

    // Write 1: AW and W in the same cycle, OKAY response
    nxt; lite_aw_valid = 1; lite_aw_addr = 32'h1000;
    lite_w_valid = 1; lite_w_data = 64'hDEADBEEF_CAFEF00D; lite_w_strb = 8'hFF; #1;
    check("w1_aw_ready", lite_aw_ready, 1);
    check("w1_w_ready", lite_w_ready, 1);
    check("w1_axi_aw_valid_pre", axi_aw_valid, 0);
    nxt; lite_aw_valid = 0; lite_w_valid = 0; axi_aw_ready = 1; axi_w_ready = 1; #1;
    check("w1_axi_aw_valid", axi_aw_valid, 1);
    check("w1_axi_w_valid", axi_w_valid, 1);
    check("w1_aw_addr", axi_aw_addr, 64'h1000);
    check("w1_aw_len", axi_aw_len, 0);
    check("w1_aw_size", axi_aw_size, 3);
    check("w1_aw_burst", axi_aw_burst, 1);
    check("w1_aw_id", axi_aw_id, 0);
    check("w1_w_last", axi_w_last, 1);
    check("w1_w_data", axi_w_data, 64'hDEADBEEF_CAFEF00D);
    check("w1_w_strb", axi_w_strb, 64'hFF);
    check("w1_lite_aw_ready_busy", lite_aw_ready, 0);
    nxt; axi_aw_ready = 0; axi_w_ready = 0; axi_b_valid = 1; axi_b_resp = 2'b00; lite_b_ready = 1; #1;
    check("w1_axi_aw_valid_done", axi_aw_valid, 0);
    check("w1_axi_w_valid_done", axi_w_valid, 0);
    check("w1_lite_b_valid", lite_b_valid, 1);
    check("w1_lite_b_resp", lite_b_resp, 0);
    check("w1_axi_b_ready", axi_b_ready, 1);
    nxt; axi_b_valid = 0; lite_b_ready = 0; #1;
    check("w1_b_valid_after", lite_b_valid, 0);
    check("w1_aw_ready_after", lite_aw_ready, 1);

    // Write 2: W ahead of AW, AXI aw_ready held low, SLVERR response
    lite_w_valid = 1; lite_w_data = 64'h0123_4567_89AB_CDEF; lite_w_strb = 8'h0F;
    nxt; lite_w_valid = 0; #1;
    check("w2_w_ready_full", lite_w_ready, 0);
    check("w2_aw_ready_open", lite_aw_ready, 1);
    check("w2_axi_w_valid_wait", axi_w_valid, 0);
    nxt; nxt; lite_aw_valid = 1; lite_aw_addr = 32'h3000;
    nxt; lite_aw_valid = 0; axi_w_ready = 1; axi_aw_ready = 0; #1;
    check("w2_axi_aw_valid", axi_aw_valid, 1);
    check("w2_axi_w_valid", axi_w_valid, 1);
    check("w2_w_strb", axi_w_strb, 64'h0F);
    lite_aw_valid = 1; lite_aw_addr = 32'h4000; lite_w_valid = 1;
    for (int i = 0; i < 3; i++) begin
      nxt; axi_w_ready = 0; #1;
      check("w2_aw_valid_held", axi_aw_valid, 1);
      check("w2_aw_addr_stable", axi_aw_addr, 64'h3000);
      check("w2_w_valid_dropped", axi_w_valid, 0);
      check("w2_no_second_aw", lite_aw_ready, 0);
      check("w2_no_second_w", lite_w_ready, 0);
    end
    nxt; axi_aw_ready = 1; #1;
    check("w2_aw_valid_final", axi_aw_valid, 1);
    nxt; axi_aw_ready = 0; axi_b_valid = 1; axi_b_resp = 2'b10; lite_b_ready = 0; #1;
    check("w2_aw_valid_done", axi_aw_valid, 0);
    check("w2_lite_b_valid", lite_b_valid, 1);
    check("w2_lite_b_resp", lite_b_resp, 2'b10);
    check("w2_axi_b_ready_low", axi_b_ready, 0);
    check("w2_resp_aw_ready", lite_aw_ready, 0);
    nxt; lite_b_ready = 1; #1;
    check("w2_axi_b_ready", axi_b_ready, 1);
    nxt; axi_b_valid = 0; lite_b_ready = 0; lite_aw_valid = 0; lite_w_valid = 0; #1;
    check("w2_single_b", lite_b_valid, 0);
    check("w2_idle_aw_ready", lite_aw_ready, 1);
    check("w2_idle_w_ready", lite_w_ready, 1);

    // Read 1 concurrent with a pending (AW-only) write, Lite r_ready back-pressure
    lite_aw_valid = 1; lite_aw_addr = 32'h5000;
    nxt; lite_aw_valid = 0; lite_ar_valid = 1; lite_ar_addr = 32'h2004; #1;
    check("r1_ar_ready", lite_ar_ready, 1);
    check("r1_aw_buffered", lite_aw_ready, 0);
    check("r1_no_aw_issue", axi_aw_valid, 0);
    nxt; lite_ar_valid = 0; axi_ar_ready = 1; #1;
    check("r1_axi_ar_valid", axi_ar_valid, 1);
    check("r1_ar_addr", axi_ar_addr, 64'h2004);
    check("r1_ar_id", axi_ar_id, 0);
    check("r1_ar_len", axi_ar_len, 0);
    check("r1_ar_size", axi_ar_size, 3);
    check("r1_ar_burst", axi_ar_burst, 1);
    check("r1_ar_ready_busy", lite_ar_ready, 0);
    nxt; axi_ar_ready = 0; axi_r_valid = 1; axi_r_data = 64'h11223344_55667788; axi_r_resp = 0; lite_r_ready = 0; #1;
    check("r1_ar_valid_done", axi_ar_valid, 0);
    check("r1_lite_r_valid", lite_r_valid, 1);
    check("r1_r_data", lite_r_data, 64'h11223344_55667788);
    check("r1_axi_r_ready_low", axi_r_ready, 0);
    nxt; #1;
    check("r1_r_valid_held", lite_r_valid, 1);
    check("r1_r_data_stable", lite_r_data, 64'h11223344_55667788);
    nxt; lite_r_ready = 1; #1;
    check("r1_axi_r_ready", axi_r_ready, 1);
    check("r1_r_resp", lite_r_resp, 0);
    nxt; axi_r_valid = 0; lite_r_ready = 0; #1;
    check("r1_r_valid_after", lite_r_valid, 0);
    check("r1_ar_ready_after", lite_ar_ready, 1);

    // Read 2: DECERR passes through
    lite_ar_valid = 1; lite_ar_addr = 32'h2008;
    nxt; lite_ar_valid = 0; axi_ar_ready = 1;
    nxt; axi_ar_ready = 0; axi_r_valid = 1; axi_r_resp = 2'b11; lite_r_ready = 1; #1;
    check("r2_r_valid", lite_r_valid, 1);
    check("r2_r_resp_decerr", lite_r_resp, 2'b11);
    nxt; axi_r_valid = 0; lite_r_ready = 0; axi_r_resp = 0;

    // Read 3: unexpected r_id
    lite_ar_valid = 1; lite_ar_addr = 32'h200C;
    nxt; lite_ar_valid = 0; axi_ar_ready = 1;
    nxt; axi_ar_ready = 0; axi_r_valid = 1; axi_r_id = 10'd1; axi_r_resp = 0; lite_r_ready = 1; #1;
    check("r3_r_valid", lite_r_valid, 1);
    check("r3_r_resp_bad_id", lite_r_resp, exp_id_resp);
    nxt; axi_r_valid = 0; lite_r_ready = 0; axi_r_id = '0; #1;
    check("r3_ar_ready_after", lite_ar_ready, 1);

    // Reset while in W_ISSUE (AW 0x5000 still buffered; supply W now)
    lite_w_valid = 1; lite_w_data = 64'hAAAA_5555_AAAA_5555; lite_w_strb = 8'hFF;
    nxt; lite_w_valid = 0; #1;
    check("rst_mid_aw_valid", axi_aw_valid, 1);
    check("rst_mid_aw_addr", axi_aw_addr, 64'h5000);
    check("rst_mid_w_valid", axi_w_valid, 1);
    #2 Rst_RBI = 1'b0; #1;
    check("rst_mid_aw_drop", axi_aw_valid, 0);
    check("rst_mid_w_drop", axi_w_valid, 0);
    check("rst_mid_aw_ready_gated", lite_aw_ready, 0);
    check("rst_mid_ar_ready_gated", lite_ar_ready, 0);
    nxt; Rst_RBI = 1'b1; #1;
    check("rst_rel_aw_ready", lite_aw_ready, 1);
    check("rst_rel_w_ready", lite_w_ready, 1);
    check("rst_rel_aw_valid", axi_aw_valid, 0);
    lite_aw_valid = 1; lite_aw_addr = 32'h6000;
    nxt; lite_aw_valid = 0; #1;
    check("rst_rel_w_buf_empty", axi_aw_valid, 0);
    check("rst_rel_w_ready_still", lite_w_ready, 1);
    check("rst_rel_aw_buffered", lite_aw_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
